// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: FIFO-buffered J/K command driver with an expected-Q model.
// Define JKSEQ_CHECK_EN to check q_fb/qbar_fb against the model at command end.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic             cmd_ready,
    output logic             J,
    output logic             K,
    input  logic             q_fb,
    input  logic             qbar_fb,
    output logic             busy,
    output logic             done,
    output logic             exp_q,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      mem_q [DEPTH];
    logic [1:0]      mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     occ_q, occ_d;
    logic [1:0]      cmd_r_q, cmd_r_d;
    logic            j_q, j_d;
    logic            k_q, k_d;
    logic            done_q, done_d;
    logic            exp_q_q, exp_q_d;
    logic            full, empty, push, pop;
    logic            nxt_exp, chk_exp;

    assign full  = (occ_q == (PW+1)'(DEPTH));
    assign empty = (occ_q == '0);
    assign push  = cmd_valid && !full;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = cmd;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        occ_d = occ_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_comb begin
        nxt_exp = exp_q_q;
        unique case (cmd_r_q)
            2'b01:   nxt_exp = 1'b0;
            2'b10:   nxt_exp = 1'b1;
            2'b11:   nxt_exp = ~exp_q_q;
            default: nxt_exp = exp_q_q;
        endcase
    end

`ifdef JKSEQ_CHECK_EN
    logic             chk_fail, fb_known;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // X/Z on the feedback counts as a failure but is never adopted as exp_q
    always_comb begin
        chk_fail   = (q_fb !== nxt_exp) || (qbar_fb !== ~q_fb);
        fb_known   = (q_fb === 1'b0) || (q_fb === 1'b1);
        chk_exp    = (chk_fail && fb_known) ? q_fb : nxt_exp;
        mismatch_d = (state_q == S_WAIT) && chk_fail;
        err_cnt_d  = err_cnt_q;
        if (mismatch_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            mismatch_q <= mismatch_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign mismatch = mismatch_q;
    assign err_cnt  = err_cnt_q;
`else
    logic unused_fb;

    assign unused_fb = q_fb ^ qbar_fb;
    assign chk_exp   = nxt_exp;
    assign mismatch  = 1'b0;
    assign err_cnt   = '0;
`endif

    always_comb begin
        state_d = state_q;
        cmd_r_d = cmd_r_q;
        j_d     = j_q;
        k_d     = k_q;
        done_d  = 1'b0;
        exp_q_d = exp_q_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                j_d     = 1'b0;
                k_d     = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                done_d  = 1'b1;
                exp_q_d = chk_exp;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_DRIVE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            cmd_r_d = mem_q[rd_ptr_q];
            j_d     = mem_q[rd_ptr_q][1];
            k_d     = mem_q[rd_ptr_q][0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cmd_r_q  <= 2'b00;
            j_q      <= 1'b0;
            k_q      <= 1'b0;
            done_q   <= 1'b0;
            exp_q_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cmd_r_q  <= cmd_r_d;
            j_q      <= j_d;
            k_q      <= k_d;
            done_q   <= done_d;
            exp_q_q  <= exp_q_d;
            mem_q    <= mem_d;
        end
    end

    assign cmd_ready = !full;
    assign J         = j_q;
    assign K         = k_q;
    assign busy      = (state_q != S_IDLE) || !empty;
    assign done      = done_q;
    assign exp_q     = exp_q_q;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb_jk_cmd_sequencer: directed stimulus, schedule-based reference model.
// A behavioural JK master-slave flop closes the q_fb/qbar_fb loop.
module tb_jk_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd = 2'b00;
    logic             cmd_ready, J, K, busy, done, exp_q, mismatch;
    logic [CNT_W-1:0] err_cnt;
    logic             q_fb, qbar_fb;
    logic             ff_m = 1'b0;
    logic             ff_s = 1'b0;
    logic             fault = 1'b0;

    int vectors = 0;
    int errors  = 0;
    int mis_cnt = 0;
    bit chk_en  = 1'b0;
    bit saw_not_ready = 1'b0;
    logic log_q[$];

    jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ready(cmd_ready), .J(J), .K(K), .q_fb(q_fb), .qbar_fb(qbar_fb),
        .busy(busy), .done(done), .exp_q(exp_q), .mismatch(mismatch),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Master samples J/K on the rising edge, slave follows on the falling edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff_m <= 1'b0;
        else if (J && K) ff_m <= ~ff_s;
        else if (J) ff_m <= 1'b1;
        else if (K) ff_m <= 1'b0;
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) ff_s <= 1'b0;
        else ff_s <= ff_m;
    end

    assign q_fb    = fault ? 1'b0 : ff_s;
    assign qbar_fb = ~q_fb;

    // Reference model: each command occupies the two edges after its pop
    logic [1:0]       mq[$];
    logic             m_j = 0, m_k = 0, m_done = 0, m_exp = 0, m_mis = 0;
    logic             m_ready = 1, m_busy = 0, m_nv;
    logic [CNT_W-1:0] m_err = '0;
    logic [1:0]       m_c, comp_cmd = 2'b00;
    int               m_edge = 0, comp_edge = 0;
    bit               comp_valid = 1'b0, m_take;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_j = 0; m_k = 0; m_done = 0; m_exp = 0; m_mis = 0;
            m_err = '0;
            comp_valid = 1'b0;
        end else begin
            m_edge++;
            m_done = 0; m_mis = 0; m_j = 0; m_k = 0;
            m_take = cmd_valid && (mq.size() < DEPTH);
            if (comp_valid && comp_edge == m_edge) begin
                comp_valid = 1'b0;
                m_done = 1;
                case (comp_cmd)
                    2'b01:   m_nv = 1'b0;
                    2'b10:   m_nv = 1'b1;
                    2'b11:   m_nv = ~m_exp;
                    default: m_nv = m_exp;
                endcase
`ifdef JKSEQ_CHECK_EN
                if ((q_fb !== m_nv) || (qbar_fb !== ~q_fb)) begin
                    m_mis = 1;
                    if (m_err != {CNT_W{1'b1}}) m_err++;
                    if (q_fb === 1'b0 || q_fb === 1'b1) m_nv = q_fb;
                end
`endif
                m_exp = m_nv;
            end
            if (!comp_valid && mq.size() > 0) begin
                m_c = mq.pop_front();
                m_j = m_c[1];
                m_k = m_c[0];
                comp_cmd = m_c;
                comp_edge = m_edge + 2;
                comp_valid = 1'b1;
            end
            if (m_take) mq.push_back(cmd);
        end
        m_ready = (mq.size() < DEPTH);
        m_busy  = (mq.size() > 0) || comp_valid;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("J", J, m_j);
            check("K", K, m_k);
            check("done", done, m_done);
            check("exp_q", exp_q, m_exp);
            check("busy", busy, m_busy);
            check("cmd_ready", cmd_ready, m_ready);
            check("mismatch", mismatch, m_mis);
            check("err_cnt", err_cnt, m_err);
            if (done === 1'b1) log_q.push_back(exp_q);
            if (mismatch === 1'b1) mis_cnt++;
            if (cmd_ready === 1'b0) saw_not_ready = 1'b1;
        end
    end

    // Called just after a falling edge; returns just after the falling edge
    // that follows the accepting rising edge.
    task automatic send(input logic [1:0] c);
        logic r;
        bit ok;
        ok = 1'b0;
        cmd_valid = 1'b1;
        cmd = c;
        for (int i = 0; i < 50 && !ok; i++) begin
            r = cmd_ready;
            @(negedge clk);
            if (r) ok = 1'b1;
        end
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_log(input string nm, input logic exp_seq[$]);
        check({nm, "_count"}, log_q.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < log_q.size(); i++) begin
            check(nm, log_q[i], exp_seq[i]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seq2[$];
        logic seq3[$];
        logic seq5[$];
        seq2 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        seq3 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        seq5 = '{1'b1, 1'b0};

        @(negedge clk);
        chk_en = 1'b1;
        #1;
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_jk", {J, K}, 0);
        check("rst_exp", exp_q, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // single set: J high one cycle, done three edges after push
        send(2'b10);
        cmd_valid = 1'b0;
        @(negedge clk); #1;
        check("t1_jk_on", {J, K}, 2'b10);
        @(negedge clk); #1;
        check("t1_jk_off", {J, K}, 2'b00);
        @(negedge clk); #1;
        check("t1_done", done, 1);
        check("t1_exp", exp_q, 1);
        check("t1_ff_q", q_fb, 1);
        idle(3);

        // back-to-back commands
        log_q.delete();
        send(2'b10); send(2'b11); send(2'b11); send(2'b01); send(2'b00);
        idle(15);
        check_log("t2_seq", seq2);

        // continuous offer fills the FIFO
        log_q.delete();
        saw_not_ready = 1'b0;
        send(2'b10); send(2'b01); send(2'b10); send(2'b01);
        send(2'b11); send(2'b11); send(2'b00); send(2'b10);
        idle(20);
        check("t3_full_seen", saw_not_ready, 1);
        check_log("t3_seq", seq3);

        // async reset while driving with commands queued
        log_q.delete();
        send(2'b10); send(2'b11); send(2'b01);
        send(2'b10); send(2'b11); send(2'b01);
        cmd_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("t5_jk", {J, K}, 0);
        check("t5_busy", busy, 0);
        check("t5_ready", cmd_ready, 1);
        check("t5_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        check("t5_idle_busy", busy, 0);
        check_log("t5_seq", seq5);

        // push lands on the WAIT-exit edge: no bypass
        send(2'b11);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        send(2'b11);
        cmd_valid = 1'b0;
        #1;
        check("t6_done", done, 1);
        check("t6_no_bypass", {J, K}, 0);
        check("t6_busy", busy, 1);
        @(negedge clk); #1;
        check("t6_pop_next", {J, K}, 2'b11);
        idle(6);
        check("t6_exp", exp_q, 0);

`ifdef JKSEQ_CHECK_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        mis_cnt = 0;
        fault = 1'b1;
        send(2'b10);
        idle(6);
        check("t4_err1", err_cnt, 1);
        check("t4_mis1", mis_cnt, 1);
        check("t4_resync", exp_q, 0);
        for (int i = 0; i < 260; i++) send(2'b10);
        idle(6);
        check("t4_sat", err_cnt, 255);
        fault = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        check("t4_rst_err", err_cnt, 0);
`else
        check("nochk_mis", mis_cnt, 0);
        check("nochk_err", err_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
